// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    localparam int MAX_W = 32;
    typedef logic [MAX_W-1:0] word_t;

    // Smallest legal divisor: one cycle high, one cycle low.
    localparam word_t DIV_MIN = 32'd2;

    typedef struct packed {
        word_t div;
        word_t hi;
    } chan_cfg_t;

    // Width of a channel index; never zero so a single-channel build still has a port.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic word_t clamp_div(input word_t v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

    // High time must leave at least one high and one low cycle in the period.
    function automatic word_t clamp_hi(input word_t h, input word_t n);
        if (h == 32'd0)
            return 32'd1;
        else if (h >= n)
            return n - 32'd1;
        else
            return h;
    endfunction

    function automatic word_t half_up(input word_t n);
        return (n + 32'd1) >> 1;
    endfunction

    function automatic chan_cfg_t reset_cfg(input word_t div);
        chan_cfg_t c;
        c.div = clamp_div(div);
        c.hi  = half_up(c.div);
        return c;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active divisor and high time, registered outputs.
// Latency: outputs registered, one clk after the controlling input is sampled.
// Backpressure: none; writes land in the shadow and take effect at wrap, enable rise or sync.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_val,
    input  logic             hi_wr,
    input  logic [CNT_W-1:0] hi_val,
    output logic             clk_out,
    output logic             tick
);

    localparam chan_cfg_t        RST_CFG = reset_cfg(word_t'(DEFAULT_DIV));
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RST_CFG.div);
    localparam logic [CNT_W-1:0] RST_HI  = CNT_W'(RST_CFG.hi);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow_div, shadow_hi;
    logic [CNT_W-1:0] active_div, active_hi;
    logic             run;

    logic [CNT_W-1:0] sdiv_nxt, shi_nxt, ld_hi;
    logic [CNT_W-1:0] cnt_inc, div_m1;
    logic             wrap, reload;

    // Next shadow values (same-cycle write is visible to a reload) and period-boundary detection.
    always_comb begin
        sdiv_nxt = shadow_div;
        shi_nxt  = shadow_hi;
        if (div_wr)
            sdiv_nxt = CNT_W'(clamp_div(word_t'(div_val)));
        if (hi_wr)
            shi_nxt = hi_val;
        // High time is clamped against the divisor it is applied with, not the one it was written with.
        ld_hi   = CNT_W'(clamp_hi(word_t'(shi_nxt), word_t'(sdiv_nxt)));
        cnt_inc = cnt + CNT_W'(1);
        div_m1  = active_div - CNT_W'(1);
        wrap    = (cnt == div_m1);
        reload  = !run || sync || wrap;
    end

    // Counter, shadow/active registers and registered waveform/tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            shadow_div <= RST_DIV;
            shadow_hi  <= RST_HI;
            active_div <= RST_DIV;
            active_hi  <= RST_HI;
            run        <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            shadow_div <= sdiv_nxt;
            shadow_hi  <= shi_nxt;
            run        <= en;
            if (!en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (reload) begin
                cnt        <= '0;
                clk_out    <= 1'b1;
                tick       <= 1'b0;
                active_div <= sdiv_nxt;
                active_hi  <= ld_hi;
            end else begin
                cnt     <= cnt_inc;
                clk_out <= (cnt_inc < active_hi);
                tick    <= (cnt_inc == div_m1);
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// NCH runtime-programmable clock dividers with per-channel enable, wrap tick and global sync.
// Latency: all outputs registered, one clk after inputs; divisor changes apply at period boundary.
// Backpressure: none; optional duty-cycle programming with CLK_DIV_DUTY_EN.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic                   div_wr,
    input  logic [ch_w(NCH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]       div_val,
    input  logic                   sync,
`ifdef CLK_DIV_DUTY_EN
    input  logic                   duty_wr,
    input  logic [CNT_W-1:0]       duty_val,
`endif
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick
);

    localparam int CH_W = ch_w(NCH);

    logic [NCH-1:0]   div_sel, hi_sel;
    logic [CNT_W-1:0] hi_dat;

    // Decode the channel index into per-channel strobes; indices >= NCH select nothing.
    always_comb begin
        div_sel = '0;
        hi_sel  = '0;
`ifdef CLK_DIV_DUTY_EN
        hi_dat = duty_val;
`else
        // Without duty programming the high time follows the divisor as ceil(N/2).
        hi_dat = CNT_W'(half_up(clamp_div(word_t'(div_val))));
`endif
        for (int i = 0; i < NCH; i++) begin
            if (div_ch == CH_W'(i)) begin
                div_sel[i] = div_wr;
`ifdef CLK_DIV_DUTY_EN
                hi_sel[i]  = duty_wr;
`else
                hi_sel[i]  = div_wr;
`endif
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .sync    (sync),
            .div_wr  (div_sel[g]),
            .div_val (div_val),
            .hi_wr   (hi_sel[g]),
            .hi_val  (hi_dat),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
`timescale 1ns/1ps
// Directed bench for clk_div_multi: table of divisors plus hand-written corner sequences.
module tb_clk_div_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             div_wr;
    logic [1:0]       div_ch;
    logic [CNT_W-1:0] div_val;
    logic             sync;
    logic [NCH-1:0]   clk_out, tick;
`ifdef CLK_DIV_DUTY_EN
    logic             duty_wr;
    logic [CNT_W-1:0] duty_val;
`endif

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        int div;
        int high;
        int period;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(40)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .sync     (sync),
`ifdef CLK_DIV_DUTY_EN
        .duty_wr  (duty_wr),
        .duty_val (duty_val),
`endif
        .clk_out  (clk_out),
        .tick     (tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_div(input int ch, input int val);
        div_wr  = 1'b1;
        div_ch  = 2'(ch);
        div_val = CNT_W'(val);
        step(1);
        div_wr  = 1'b0;
    endtask

`ifdef CLK_DIV_DUTY_EN
    task automatic wr_duty(input int ch, input int val);
        duty_wr  = 1'b1;
        div_ch   = 2'(ch);
        duty_val = CNT_W'(val);
        step(1);
        duty_wr  = 1'b0;
    endtask
`endif

    // Program divisor and, where duty is programmable, the matching ceil(N/2) high time.
    task automatic set_n(input int ch, input int n, input int h);
        wr_div(ch, n);
`ifdef CLK_DIV_DUTY_EN
        wr_duty(ch, h);
`else
        if (h < 0) $display("note: negative high time ignored");
`endif
    endtask

    // Sample one channel for n cycles starting at the current sample.
    task automatic measure(input int ch, input int n, output int highs, output int ticks,
                           output int tpos, output int others);
        highs = 0; ticks = 0; tpos = -1; others = 0;
        for (int i = 0; i < n; i++) begin
            highs += int'(clk_out[ch]);
            if (tick[ch]) begin
                ticks++;
                tpos = i;
            end
            for (int c = 0; c < NCH; c++)
                if (c != ch && (clk_out[c] || tick[c])) others++;
            step(1);
        end
    endtask

    initial begin
        int hi, tk, tp, ot, t0, t2, both;

        vecs[0] = '{40, 20, 40};
        vecs[1] = '{6,  3,  6};
        vecs[2] = '{5,  3,  5};
        vecs[3] = '{7,  4,  7};
        vecs[4] = '{3,  2,  3};
        vecs[5] = '{2,  1,  2};
        vecs[6] = '{1,  1,  2};
        vecs[7] = '{0,  1,  2};

        rst = 1'b0; en = '0; div_wr = 1'b0; div_ch = '0; div_val = '0; sync = 1'b0;
`ifdef CLK_DIV_DUTY_EN
        duty_wr = 1'b0; duty_val = '0;
`endif
        #2;
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);
        step(2);
        rst = 1'b1;
        step(1);
        check("idle_clk_out", 32'(clk_out), 0);

        // Test 1: ch0 at default N=40.
        en = 4'b0001;
        step(1);
        measure(0, 40, hi, tk, tp, ot);
        check("t1_high", hi, 20);
        check("t1_ticks", tk, 1);
        check("t1_tick_pos", tp, 39);
        check("t1_others_quiet", ot, 0);
        check("t1_next_period_high", 32'(clk_out[0]), 1);

        // Test 2: mid-period divisor write on ch1 applies only after the current period.
        en = 4'b0010;
        step(1);
        hi = 0; tk = 0; tp = -1;
        for (int k = 0; k < 40; k++) begin
            hi += int'(clk_out[1]);
            if (tick[1]) begin tk++; tp = k; end
            if (k == 10) begin div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd6; end
`ifdef CLK_DIV_DUTY_EN
            if (k == 11) begin duty_wr = 1'b1; div_ch = 2'd1; duty_val = 16'd3; end
`endif
            step(1);
            div_wr = 1'b0;
`ifdef CLK_DIV_DUTY_EN
            duty_wr = 1'b0;
`endif
        end
        check("t2_old_high", hi, 20);
        check("t2_old_tick_pos", tp, 39);
        measure(1, 6, hi, tk, tp, ot);
        check("t2_new_high", hi, 3);
        check("t2_new_tick_pos", tp, 5);
        measure(1, 6, hi, tk, tp, ot);
        check("t2_new_ticks", tk, 1);
        check("t2_ch0_off", ot, 0);

        // Table: reprogram ch1 while disabled, enable, check one period.
        en = '0;
        step(1);
        foreach (vecs[v]) begin
            set_n(1, vecs[v].div, vecs[v].high);
            en = 4'b0010;
            step(1);
            measure(1, vecs[v].period, hi, tk, tp, ot);
            check($sformatf("vec%0d_high", v), hi, vecs[v].high);
            check($sformatf("vec%0d_ticks", v), tk, 1);
            check($sformatf("vec%0d_tick_pos", v), tp, vecs[v].period - 1);
            check($sformatf("vec%0d_rewrap", v), 32'(clk_out[1]), 1);
            en = '0;
            step(1);
            check($sformatf("vec%0d_off", v), 32'(clk_out[1]), 0);
        end

        // Test 4: sync realigns ch0 (N=4) and ch2 (N=7); ch1 disabled ignores it.
        set_n(0, 4, 2);
        set_n(2, 7, 4);
        en = 4'b0101;
        step(1);
        step(9);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        check("t4_ch0_restart", 32'(clk_out[0]), 1);
        check("t4_ch2_restart", 32'(clk_out[2]), 1);
        check("t4_ticks_low", 32'({tick[2], tick[0]}), 0);
        check("t4_ch1_ignores", 32'(clk_out[1]), 0);
        t0 = 0; t2 = 0; both = -1;
        for (int k = 0; k < 28; k++) begin
            t0 += int'(tick[0]);
            t2 += int'(tick[2]);
            if (tick[0] && tick[2] && both < 0) both = k;
            step(1);
        end
        check("t4_ch0_ticks", t0, 7);
        check("t4_ch2_ticks", t2, 4);
        check("t4_first_joint_tick", both, 27);

        // Divisor write in the same cycle as sync is applied by that sync.
`ifdef CLK_DIV_DUTY_EN
        wr_duty(2, 3);
`endif
        sync = 1'b1; div_wr = 1'b1; div_ch = 2'd2; div_val = 16'd5;
        step(1);
        sync = 1'b0; div_wr = 1'b0;
        measure(2, 5, hi, tk, tp, ot);
        check("sync_wr_high", hi, 3);
        check("sync_wr_tick_pos", tp, 4);

        // Test 5: drop ch0 enable mid-period, queue writes (last wins), reassert.
        set_n(0, 40, 20);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(5);
        check("t5_running", 32'(clk_out[0]), 1);
        en[0] = 1'b0;
        step(1);
        check("t5_off_clk", 32'(clk_out[0]), 0);
        check("t5_off_tick", 32'(tick[0]), 0);
        wr_div(0, 10);
        set_n(0, 8, 4);
        check("t5_still_off", 32'(clk_out[0]), 0);
        en[0] = 1'b1;
        step(1);
        check("t5_restart_high", 32'(clk_out[0]), 1);
        measure(0, 8, hi, tk, tp, ot);
        check("t5_high", hi, 4);
        check("t5_tick_pos", tp, 7);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        #3;
        rst = 1'b0;
        #1;
        check("arst_clk_out", 32'(clk_out), 0);
        check("arst_tick", 32'(tick), 0);
        step(2);
        check("arst_held", 32'(clk_out), 0);
        #3;
        rst = 1'b1;
        en = 4'b0001;
        step(1);
        check("arst_restart_high", 32'(clk_out[0]), 1);
        measure(0, 40, hi, tk, tp, ot);
        check("arst_default_high", hi, 20);
        check("arst_default_tick_pos", tp, 39);

`ifdef CLK_DIV_DUTY_EN
        // Duty programming on ch3 with N=10: H=3, H=0 clamps to 1, H=12 clamps to 9.
        begin
            int hs[3];
            int he[3];
            hs = '{3, 0, 12};
            he = '{3, 1, 9};
            en = '0;
            step(1);
            wr_div(3, 10);
            for (int j = 0; j < 3; j++) begin
                wr_duty(3, hs[j]);
                en = 4'b1000;
                step(1);
                measure(3, 10, hi, tk, tp, ot);
                check($sformatf("duty%0d_high", j), hi, he[j]);
                check($sformatf("duty%0d_tick_pos", j), tp, 9);
                en = '0;
                step(1);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
